// File: rtl/reglist_sequencer.sv
// ----------------------------------------------------------------------------
// reglist_sequencer
//
// Walks an LDM/STM register list one register at a time. A WIDTH-bit mask is
// loaded on an accepted start, and each accepted transfer (valid & ack) retires
// the register currently presented, lowest-first or highest-first. The
// popcount of the loaded mask is kept on count for base-address writeback.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       load request, honoured only while busy=0
//   start_mask  register list captured on an accepted start
//   descending  1 = highest register first, captured on an accepted start
//   ack         consumer takes the current index (ignored while valid=0)
//   abort       drop the list in progress and return to idle
//   busy        list in progress (RUN or DONE)
//   valid       index/first/last are meaningful
//   index       current register number (0 while valid=0)
//   first       current index is the first of the list
//   last        current index is the only register remaining
//   count       popcount of the most recently accepted start_mask
//   done        one-cycle pulse when a list completes without abort
// ----------------------------------------------------------------------------
module reglist_sequencer #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_mask,
    input  logic             descending,
    input  logic             ack,
    input  logic             abort,
    output logic             busy,
    output logic             valid,
    output logic [IDX_W-1:0] index,
    output logic             first,
    output logic             last,
    output logic [IDX_W:0]   count,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mask_r;
    logic             desc_r;
    logic             first_r;
    logic [IDX_W-1:0] sel_idx;
    logic             one_left;
    logic             mask_empty;

    // Population count of a candidate list; needs IDX_W+1 bits so that a
    // full mask reports WIDTH rather than wrapping to zero.
    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] m);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IDX_W+1)'(m[i]);
        end
        return c;
    endfunction

    // Priority select of the next register. The later loop iteration wins,
    // so scanning upward finds the highest set bit and scanning downward
    // finds the lowest.
    always_comb begin
        sel_idx = '0;
        if (desc_r) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (mask_r[i]) sel_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (mask_r[i]) sel_idx = IDX_W'(i);
            end
        end
    end

    // Exactly one bit left: non-zero and clearing the lowest set bit empties it.
    assign mask_empty = (mask_r == '0);
    assign one_left   = !mask_empty && ((mask_r & (mask_r - WIDTH'(1))) == '0);

    // An empty list still passes through RUN for one cycle with nothing to
    // present, so valid is qualified by a non-empty mask. This keeps busy up
    // for two cycles and places done two cycles after start, as for a list
    // whose single entry is acked at once.
    assign busy  = (state != IDLE);
    assign valid = (state == RUN) && !mask_empty;
    assign done  = (state == DONE);
    assign index = valid ? sel_idx : '0;
    assign first = valid & first_r;
    assign last  = valid & one_left;

    // Sequencer state. Abort beats ack in RUN; in IDLE start beats abort.
    // A start while busy is simply not looked at, so mask/count/direction
    // of the running list are untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mask_r  <= '0;
            desc_r  <= 1'b0;
            first_r <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_r  <= start_mask;
                        desc_r  <= descending;
                        first_r <= 1'b1;
                        count   <= popcount(start_mask);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        mask_r  <= '0;
                        first_r <= 1'b0;
                        state   <= IDLE;
                    end else if (mask_empty) begin
                        first_r <= 1'b0;
                        state   <= DONE;
                    end else if (ack) begin
                        mask_r  <= mask_r & ~(WIDTH'(1) << sel_idx);
                        first_r <= 1'b0;
                        if (one_left) state <= DONE;
                    end
                end
                DONE: begin
                    mask_r  <= '0;
                    first_r <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    mask_r  <= '0;
                    first_r <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reglist_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reglist_sequencer
//
// Directed bench for reglist_sequencer. Inputs change 1 time unit after the
// rising edge; outputs are examined before the next edge. Expected values
// are written out by hand, plus a small ordering model for random lists.
// ----------------------------------------------------------------------------
module tb_reglist_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] start_mask;
    logic        descending;
    logic        ack;
    logic        abort;
    logic        busy;
    logic        valid;
    logic [3:0]  index;
    logic        first;
    logic        last;
    logic [4:0]  count;
    logic        done;

    int errors;
    int checks;
    int xfers;
    int dones;

    reglist_sequencer #(.WIDTH(16), .IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_mask (start_mask),
        .descending (descending),
        .ack        (ack),
        .abort      (abort),
        .busy       (busy),
        .valid      (valid),
        .index      (index),
        .first      (first),
        .last       (last),
        .count      (count),
        .done       (done)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally accepted transfers and done pulses as seen at the active edge.
    always @(posedge clk) begin
        if (!rst && valid && ack && !abort) xfers++;
        if (!rst && done) dones++;
    end

    // Advance one clock and step just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every DUT input at once.
    task automatic applyStimulus(input logic s, input logic [15:0] m,
                                 input logic d, input logic a, input logic ab);
        start      = s;
        start_mask = m;
        descending = d;
        ack        = a;
        abort      = ab;
    endtask

    // Compare the full handshake/output view against expectations.
    task automatic checkOutput(input string tag, input logic eb, input logic ev,
                               input logic [3:0] ei, input logic ef,
                               input logic el, input logic ed);
        logic [8:0] got;
        logic [8:0] exp;
        got = {busy, valid, index, first, last, done};
        exp = {eb, ev, ei, ef, el, ed};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got busy/valid/index/first/last/done=%b/%b/%0d/%b/%b/%b expected %b/%b/%0d/%b/%b/%b",
                   tag, got[8], got[7], got[6:3], got[2], got[1], got[0],
                   exp[8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Compare an integer quantity (count, transfer tallies).
    task automatic checkValue(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        logic [15:0] rmask;
        logic        rdesc;
        int          npop;
        int          seen;

        errors = 0;
        checks = 0;
        xfers  = 0;
        dones  = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_outputs", 0, 0, 4'd0, 0, 0, 0);
        checkValue("reset_count", int'(count), 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_after_reset", 0, 0, 4'd0, 0, 0, 0);

        // 1: 0x8421 ascending, ack held high.
        $display("[TB] test 1: 8421 ascending");
        applyStimulus(1'b1, 16'h8421, 1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("t1_idx0", 1, 1, 4'd0, 1, 0, 0);
        checkValue("t1_count", int'(count), 4);
        tick();
        checkOutput("t1_idx5", 1, 1, 4'd5, 0, 0, 0);
        tick();
        checkOutput("t1_idx10", 1, 1, 4'd10, 0, 0, 0);
        tick();
        checkOutput("t1_idx15", 1, 1, 4'd15, 0, 1, 0);
        tick();
        checkOutput("t1_done", 1, 0, 4'd0, 0, 0, 1);
        tick();
        checkOutput("t1_idle", 0, 0, 4'd0, 0, 0, 0);

        // 2: 0x8421 descending.
        $display("[TB] test 2: 8421 descending");
        applyStimulus(1'b1, 16'h8421, 1'b1, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("t2_idx15", 1, 1, 4'd15, 1, 0, 0);
        tick();
        checkOutput("t2_idx10", 1, 1, 4'd10, 0, 0, 0);
        tick();
        checkOutput("t2_idx5", 1, 1, 4'd5, 0, 0, 0);
        tick();
        checkOutput("t2_idx0", 1, 1, 4'd0, 0, 1, 0);
        tick();
        checkOutput("t2_done", 1, 0, 4'd0, 0, 0, 1);
        tick();
        checkOutput("t2_idle", 0, 0, 4'd0, 0, 0, 0);

        // 3: empty list -- busy two cycles, no valid, done at N+2.
        $display("[TB] test 3: empty list");
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("t3_n1", 1, 0, 4'd0, 0, 0, 0);
        checkValue("t3_count", int'(count), 0);
        tick();
        checkOutput("t3_done", 1, 0, 4'd0, 0, 0, 1);
        tick();
        checkOutput("t3_idle", 0, 0, 4'd0, 0, 0, 0);

        // 4: full mask ascending, ack alternating 0/1.
        $display("[TB] test 4: full mask, ack toggling");
        xfers = 0;
        dones = 0;
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        checkValue("t4_count", int'(count), 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t4_idx%0d", i), 1, 1, 4'(i), i == 0, i == 15, 0);
            ack = 1'b0;
            tick();
            checkOutput($sformatf("t4_hold%0d", i), 1, 1, 4'(i), i == 0, i == 15, 0);
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        checkOutput("t4_done", 1, 0, 4'd0, 0, 0, 1);
        tick();
        checkOutput("t4_idle", 0, 0, 4'd0, 0, 0, 0);
        checkValue("t4_xfers", xfers, 16);
        checkValue("t4_dones", dones, 1);

        // 5: abort together with ack on the second entry, then an immediate
        //    restart that also has abort high (start wins in IDLE).
        $display("[TB] test 5: abort with ack");
        dones = 0;
        applyStimulus(1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("t5_idx4", 1, 1, 4'd4, 1, 0, 0);
        ack = 1'b1;
        tick();
        checkOutput("t5_idx5", 1, 1, 4'd5, 0, 0, 0);
        abort = 1'b1;
        tick();
        checkOutput("t5_aborted", 0, 0, 4'd0, 0, 0, 0);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_restart", 1, 1, 4'd0, 1, 1, 0);
        checkValue("t5_count", int'(count), 1);
        checkValue("t5_no_done_on_abort", dones, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("t5_done", 1, 0, 4'd0, 0, 0, 1);
        tick();
        checkOutput("t5_idle", 0, 0, 4'd0, 0, 0, 0);

        // 6: start while busy is ignored; reset mid-list clears everything.
        $display("[TB] test 6: busy start and mid-list reset");
        applyStimulus(1'b1, 16'h0303, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("t6_idx0", 1, 1, 4'd0, 1, 0, 0);
        ack = 1'b1;
        tick();
        applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_idx1", 1, 1, 4'd1, 0, 0, 0);
        tick();
        start = 1'b0;
        checkOutput("t6_busy_start_ignored", 1, 1, 4'd1, 0, 0, 0);
        checkValue("t6_count_kept", int'(count), 4);
        rst = 1'b1;
        ack = 1'b1;
        tick();
        checkOutput("t6_reset", 0, 0, 4'd0, 0, 0, 0);
        checkValue("t6_reset_count", int'(count), 0);
        rst = 1'b0;
        ack = 1'b0;
        tick();
        checkOutput("t6_idle", 0, 0, 4'd0, 0, 0, 0);

        // Random lists against an order/popcount model, ack held high.
        $display("[TB] random lists");
        for (int r = 0; r < 6; r++) begin
            rmask = 16'($urandom);
            if (rmask == 16'h0000) rmask = 16'h0001;
            rdesc = 1'($urandom_range(0, 1));
            npop = 0;
            for (int b = 0; b < 16; b++) if (rmask[b]) npop++;
            applyStimulus(1'b1, rmask, rdesc, 1'b1, 1'b0);
            tick();
            start = 1'b0;
            checkValue($sformatf("rnd%0d_count", r), int'(count), npop);
            seen = 0;
            for (int k = 0; k < 16; k++) begin
                int b;
                b = rdesc ? 15 - k : k;
                if (rmask[b]) begin
                    checkOutput($sformatf("rnd%0d_idx%0d", r, b), 1, 1, 4'(b),
                                seen == 0, seen == npop - 1, 0);
                    seen++;
                    tick();
                end
            end
            ack = 1'b0;
            checkOutput($sformatf("rnd%0d_done", r), 1, 0, 4'd0, 0, 0, 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
